// File: rtl/logical_fu_sched_if.sv
// rtl/logical_fu_sched_if.sv - dispatch, CDB snoop, FU and write-back bundle for the logical FU scheduler
interface logical_fu_sched_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             disp_valid;
    logic             disp_ready;
    logic [2:0]       disp_op;
    logic [TAG_W-1:0] disp_dst_tag;
    logic             disp_src1_rdy;
    logic             disp_src2_rdy;
    logic [TAG_W-1:0] disp_src1_tag;
    logic [TAG_W-1:0] disp_src2_tag;
    logic [XLEN-1:0]  disp_src1_val;
    logic [XLEN-1:0]  disp_src2_val;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             fu_valid;
    logic [2:0]       fu_op;
    logic [XLEN-1:0]  fu_rs1;
    logic [XLEN-1:0]  fu_rs2;
    logic [XLEN-1:0]  fu_result;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_data;

    modport master (
        output disp_valid, disp_op, disp_dst_tag, disp_src1_rdy, disp_src2_rdy,
        output disp_src1_tag, disp_src2_tag, disp_src1_val, disp_src2_val,
        output cdb_valid, cdb_tag, cdb_data, fu_result,
        input  disp_ready, fu_valid, fu_op, fu_rs1, fu_rs2, wb_valid, wb_tag, wb_data
    );

    modport slave (
        input  disp_valid, disp_op, disp_dst_tag, disp_src1_rdy, disp_src2_rdy,
        input  disp_src1_tag, disp_src2_tag, disp_src1_val, disp_src2_val,
        input  cdb_valid, cdb_tag, cdb_data, fu_result,
        output disp_ready, fu_valid, fu_op, fu_rs1, fu_rs2, wb_valid, wb_tag, wb_data
    );
endinterface

// File: rtl/logical_fu_sched.sv
// rtl/logical_fu_sched.sv - reservation station with oldest-first select for the logical FU
module logical_fu_sched #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int ENTRIES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    logical_fu_sched_if.slave bus
);
    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_rdy1;
    logic [ENTRIES-1:0] r_rdy2;
    logic [2:0]         r_op   [ENTRIES];
    logic [TAG_W-1:0]   r_dst  [ENTRIES];
    logic [TAG_W-1:0]   r_tag1 [ENTRIES];
    logic [TAG_W-1:0]   r_tag2 [ENTRIES];
    logic [XLEN-1:0]    r_val1 [ENTRIES];
    logic [XLEN-1:0]    r_val2 [ENTRIES];
    // Rank 0 is the oldest valid entry; ranks stay dense 0..count-1
    logic [AW-1:0]      r_age  [ENTRIES];
    logic               r_wb_valid;
    logic [TAG_W-1:0]   r_wb_tag;

    logic               w_free_found;
    logic [AW-1:0]      w_free_idx;
    logic [AW:0]        w_count;
    logic [AW:0]        w_count_after;
    logic               w_sel_found;
    logic [AW-1:0]      w_sel_idx;
    logic [AW-1:0]      w_sel_age;
    logic               w_issue;
    logic               w_disp;
    logic               w_d1_hit;
    logic               w_d2_hit;

    // Lowest-index free slot and occupancy, both from start-of-cycle state
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_count      = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = AW'(i);
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            w_count = w_count + (AW+1)'(r_valid[i]);
        end
    end

    // Oldest entry whose operands were both ready at the start of the cycle
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_sel_age   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && r_rdy1[i] && r_rdy2[i] && (!w_sel_found || r_age[i] < w_sel_age)) begin
                w_sel_found = 1'b1;
                w_sel_idx   = AW'(i);
                w_sel_age   = r_age[i];
            end
        end
    end

    assign w_issue       = w_sel_found && !flush;
    assign w_disp        = bus.disp_valid && w_free_found && !flush;
    assign w_count_after = w_count - (AW+1)'(w_issue);
    assign w_d1_hit      = bus.cdb_valid && (bus.cdb_tag == bus.disp_src1_tag);
    assign w_d2_hit      = bus.cdb_valid && (bus.cdb_tag == bus.disp_src2_tag);

    assign bus.disp_ready = w_free_found;
    assign bus.fu_valid   = w_issue;
    assign bus.fu_op      = w_issue ? r_op[w_sel_idx]   : 3'b000;
    assign bus.fu_rs1     = w_issue ? r_val1[w_sel_idx] : '0;
    assign bus.fu_rs2     = w_issue ? r_val2[w_sel_idx] : '0;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_tag     = r_wb_tag;
    assign bus.wb_data    = r_wb_valid ? bus.fu_result : '0;

    // Entry state: CDB wakeup, issue with age compaction, and dispatch in one edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_op[i]   <= '0;
                r_dst[i]  <= '0;
                r_tag1[i] <= '0;
                r_tag2[i] <= '0;
                r_val1[i] <= '0;
                r_val2[i] <= '0;
                r_age[i]  <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (r_valid[i] && bus.cdb_valid) begin
                    if (!r_rdy1[i] && r_tag1[i] == bus.cdb_tag) begin
                        r_rdy1[i] <= 1'b1;
                        r_val1[i] <= bus.cdb_data;
                    end
                    if (!r_rdy2[i] && r_tag2[i] == bus.cdb_tag) begin
                        r_rdy2[i] <= 1'b1;
                        r_val2[i] <= bus.cdb_data;
                    end
                end
                if (w_issue && r_valid[i] && r_age[i] > w_sel_age) begin
                    r_age[i] <= r_age[i] - AW'(1);
                end
            end
            if (w_issue) begin
                r_valid[w_sel_idx] <= 1'b0;
            end
            // New entry is always youngest; rank counts survivors of this edge
            if (w_disp) begin
                r_valid[w_free_idx] <= 1'b1;
                r_op[w_free_idx]    <= bus.disp_op;
                r_dst[w_free_idx]   <= bus.disp_dst_tag;
                r_tag1[w_free_idx]  <= bus.disp_src1_tag;
                r_tag2[w_free_idx]  <= bus.disp_src2_tag;
                r_rdy1[w_free_idx]  <= bus.disp_src1_rdy || w_d1_hit;
                r_rdy2[w_free_idx]  <= bus.disp_src2_rdy || w_d2_hit;
                r_val1[w_free_idx]  <= bus.disp_src1_rdy ? bus.disp_src1_val :
                                       (w_d1_hit ? bus.cdb_data : '0);
                r_val2[w_free_idx]  <= bus.disp_src2_rdy ? bus.disp_src2_val :
                                       (w_d2_hit ? bus.cdb_data : '0);
                r_age[w_free_idx]   <= w_count_after[AW-1:0];
            end
        end
    end

    // In-flight flag and tag for the fixed one-cycle write-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_tag   <= '0;
        end else begin
            r_wb_valid <= w_issue;
            r_wb_tag   <= w_issue ? r_dst[w_sel_idx] : '0;
        end
    end
endmodule

// File: tb/tb_logical_fu_sched.sv
// tb/tb_logical_fu_sched.sv - directed vector bench for logical_fu_sched
module tb_logical_fu_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logical_fu_sched_if #(.XLEN(32), .TAG_W(6)) bus ();

    logical_fu_sched #(.XLEN(32), .TAG_W(6), .ENTRIES(4)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Registered logical FU model
    always @(posedge clk) begin
        if (!bus.fu_valid) bus.fu_result <= 32'h0;
        else case (bus.fu_op)
            3'b100:  bus.fu_result <= bus.fu_rs1 ^ bus.fu_rs2;
            3'b110:  bus.fu_result <= bus.fu_rs1 | bus.fu_rs2;
            3'b111:  bus.fu_result <= bus.fu_rs1 & bus.fu_rs2;
            default: bus.fu_result <= 32'h0;
        endcase
    end

    typedef struct {
        logic [31:0] dv, op, dst, r1, t1, v1, r2, v2, cv, ct, cd;
        logic [31:0] e_dr, e_fv, e_op, e_rs1, e_rs2, e_wv, e_wt, e_wd;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;     bus.disp_op = 3'b000;      bus.disp_dst_tag = 6'd0;
        bus.disp_src1_rdy = 1'b0;  bus.disp_src2_rdy = 1'b0;
        bus.disp_src1_tag = 6'd0;  bus.disp_src2_tag = 6'd0;
        bus.disp_src1_val = 32'h0; bus.disp_src2_val = 32'h0;
        bus.cdb_valid = 1'b0;      bus.cdb_tag = 6'd0;        bus.cdb_data = 32'h0;
        flush = 1'b0;
    endtask

    task automatic disp(input logic [2:0] op, input logic [5:0] dst, input logic r1, input logic [5:0] t1,
                        input logic [31:0] v1, input logic [31:0] v2);
        bus.disp_valid = 1'b1;  bus.disp_op = op;        bus.disp_dst_tag = dst;
        bus.disp_src1_rdy = r1; bus.disp_src1_tag = t1;  bus.disp_src1_val = v1;
        bus.disp_src2_rdy = 1'b1; bus.disp_src2_val = v2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] got_tag[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_tag[5];
    logic [31:0] exp_data[5];

    initial begin
        bus.fu_result = 32'h0;
        idle();
        //            dv op     dst r1 t1 v1            r2 v2            cv ct cd             dr fv op     rs1           rs2           wv wt wd
        vecs[0]  = '{1, 'h4,  5, 1, 0, 'hF0F0F0F0, 1, 'h0FF00FF0, 0, 0, 0,           1, 0, 0,     0,           0,           0, 0, 0};
        vecs[1]  = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 1, 'h4,  'hF0F0F0F0, 'h0FF00FF0, 0, 0, 0};
        vecs[2]  = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 0, 0,     0,           0,           1, 5, 'hFF00FF00};
        vecs[3]  = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 0, 0,     0,           0,           0, 0, 0};
        vecs[4]  = '{1, 'h7,  7, 0, 9, 0,          1, 'hFFFF0000, 0, 0, 0,           1, 0, 0,     0,           0,           0, 0, 0};
        vecs[5]  = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 0, 0,     0,           0,           0, 0, 0};
        vecs[6]  = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 0, 0,     0,           0,           0, 0, 0};
        vecs[7]  = '{0, 0,    0, 0, 0, 0,          0, 0,          1, 9, 'h12345678,  1, 0, 0,     0,           0,           0, 0, 0};
        vecs[8]  = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 1, 'h7,  'h12345678, 'hFFFF0000, 0, 0, 0};
        vecs[9]  = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 0, 0,     0,           0,           1, 7, 'h12340000};
        vecs[10] = '{1, 'h6,  3, 0, 11, 0,         1, 'h00000F00, 1, 11, 'h000000F0, 1, 0, 0,     0,           0,           0, 0, 0};
        vecs[11] = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 1, 'h6,  'h000000F0, 'h00000F00, 0, 0, 0};
        vecs[12] = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 0, 0,     0,           0,           1, 3, 'h00000FF0};
        vecs[13] = '{1, 'h1,  1, 1, 0, 1,          1, 2,          0, 0, 0,           1, 0, 0,     0,           0,           0, 0, 0};
        vecs[14] = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 1, 'h1,  1,           2,           0, 0, 0};
        vecs[15] = '{0, 0,    0, 0, 0, 0,          0, 0,          0, 0, 0,           1, 0, 0,     0,           0,           1, 1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset disp_ready", 32'(bus.disp_ready), 32'd1);
        chk("reset fu_valid",   32'(bus.fu_valid),   32'd0);
        chk("reset fu_op",      32'(bus.fu_op),      32'd0);
        chk("reset wb_valid",   32'(bus.wb_valid),   32'd0);
        chk("reset wb_tag",     32'(bus.wb_tag),     32'd0);
        chk("reset wb_data",    bus.wb_data,         32'd0);
        next_cycle();
        rst = 1'b1;

        // Table-driven single-op scenarios
        for (int i = 0; i < 16; i++) begin
            idle();
            bus.disp_valid = vecs[i].dv[0];    bus.disp_op = vecs[i].op[2:0];   bus.disp_dst_tag = vecs[i].dst[5:0];
            bus.disp_src1_rdy = vecs[i].r1[0]; bus.disp_src1_tag = vecs[i].t1[5:0]; bus.disp_src1_val = vecs[i].v1;
            bus.disp_src2_rdy = vecs[i].r2[0]; bus.disp_src2_val = vecs[i].v2;
            bus.cdb_valid = vecs[i].cv[0];     bus.cdb_tag = vecs[i].ct[5:0];   bus.cdb_data = vecs[i].cd;
            @(negedge clk);
            chk($sformatf("v%0d disp_ready", i), 32'(bus.disp_ready), vecs[i].e_dr);
            chk($sformatf("v%0d fu_valid", i),   32'(bus.fu_valid),   vecs[i].e_fv);
            chk($sformatf("v%0d fu_op", i),      32'(bus.fu_op),      vecs[i].e_op);
            chk($sformatf("v%0d fu_rs1", i),     bus.fu_rs1,          vecs[i].e_rs1);
            chk($sformatf("v%0d fu_rs2", i),     bus.fu_rs2,          vecs[i].e_rs2);
            chk($sformatf("v%0d wb_valid", i),   32'(bus.wb_valid),   vecs[i].e_wv);
            chk($sformatf("v%0d wb_tag", i),     32'(bus.wb_tag),     vecs[i].e_wt);
            chk($sformatf("v%0d wb_data", i),    bus.wb_data,         vecs[i].e_wd);
            next_cycle();
        end

        // Full station, held 5th dispatch, shared wakeup, oldest-first drain
        exp_tag  = '{10, 11, 12, 13, 30};
        exp_data = '{'h101, 'h102, 'h104, 'h108, 'h3000};
        for (int c = 0; c < 18; c++) begin
            idle();
            if (c < 4) disp(3'b110, 6'(10 + c), 1'b0, 6'd20, 32'h0, 32'h1 << c);
            else if (c < 8) disp(3'b110, 6'd30, 1'b1, 6'd0, 32'h1000, 32'h2000);
            if (c == 5) begin
                bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd20; bus.cdb_data = 32'h100;
            end
            @(negedge clk);
            if (c < 4) chk($sformatf("full c%0d disp_ready", c), 32'(bus.disp_ready), 32'd1);
            if (c == 4 || c == 5) begin
                chk($sformatf("full c%0d disp_ready", c), 32'(bus.disp_ready), 32'd0);
                chk($sformatf("full c%0d fu_valid", c),   32'(bus.fu_valid),   32'd0);
            end
            if (c == 6) begin
                chk("full c6 fu_valid", 32'(bus.fu_valid), 32'd1);
                chk("full c6 disp_ready no bypass", 32'(bus.disp_ready), 32'd0);
            end
            if (c == 7) chk("full c7 disp_ready", 32'(bus.disp_ready), 32'd1);
            if (c >= 6 && bus.wb_valid) begin
                got_tag.push_back(32'(bus.wb_tag));
                got_data.push_back(bus.wb_data);
            end
            next_cycle();
        end
        chk("age wb count", 32'(got_tag.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("age wb%0d tag", k),  (k < got_tag.size())  ? got_tag[k]  : 32'hDEAD, exp_tag[k]);
            chk($sformatf("age wb%0d data", k), (k < got_data.size()) ? got_data[k] : 32'hDEAD, exp_data[k]);
        end

        // Flush in the issue cycle
        idle();
        disp(3'b100, 6'd40, 1'b1, 6'd0, 32'h1, 32'h2);
        @(negedge clk);
        next_cycle();
        idle();
        flush = 1'b1;
        disp(3'b100, 6'd41, 1'b1, 6'd0, 32'h3, 32'h4);
        @(negedge clk);
        chk("flush N fu_valid", 32'(bus.fu_valid), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("flush N+1 wb_valid",   32'(bus.wb_valid),   32'd0);
        chk("flush N+1 disp_ready", 32'(bus.disp_ready), 32'd1);
        chk("flush N+1 fu_valid",   32'(bus.fu_valid),   32'd0);
        next_cycle();
        @(negedge clk);
        chk("flush N+2 fu_valid", 32'(bus.fu_valid), 32'd0);
        next_cycle();

        // Asynchronous reset with an op in flight and another issuing
        idle();
        disp(3'b111, 6'd50, 1'b1, 6'd0, 32'hFF, 32'h0F);
        next_cycle();
        idle();
        disp(3'b111, 6'd51, 1'b1, 6'd0, 32'hF0, 32'h3C);
        @(negedge clk);
        chk("areset pre fu_valid", 32'(bus.fu_valid), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        chk("areset pre wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("areset pre wb_tag",   32'(bus.wb_tag),   32'd50);
        chk("areset pre wb_data",  bus.wb_data,       32'h0F);
        #1 rst = 1'b0;
        #1;
        chk("areset fu_valid",   32'(bus.fu_valid),   32'd0);
        chk("areset fu_rs1",     bus.fu_rs1,          32'd0);
        chk("areset wb_valid",   32'(bus.wb_valid),   32'd0);
        chk("areset wb_tag",     32'(bus.wb_tag),     32'd0);
        chk("areset wb_data",    bus.wb_data,         32'd0);
        chk("areset disp_ready", 32'(bus.disp_ready), 32'd1);
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post-reset c%0d wb_valid", c), 32'(bus.wb_valid), 32'd0);
            chk($sformatf("post-reset c%0d fu_valid", c), 32'(bus.fu_valid), 32'd0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/logical_fu_sched.md
LOGICAL_FU_SCHED -- requirements
Module: logical_fu_sched

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter TAG_W, default 6, physical destination/source tag width.
REQ-003 SHALL have parameter ENTRIES, default 4, reservation-station depth (power of 2, 2..8).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 flush  in  1  pipeline flush; kills all entries and in-flight op.
REQ-007 disp_valid  in  1  dispatch request.
REQ-008 disp_ready  out  1  entry available.
REQ-009 disp_op  in  3  logical type: 100 XOR, 110 OR, 111 AND.
REQ-010 disp_dst_tag  in  TAG_W  destination tag.
REQ-011 disp_src1_rdy / disp_src2_rdy  in  1 each  operand already valid.
REQ-012 disp_src1_tag / disp_src2_tag  in  TAG_W each  producer tag when not ready.
REQ-013 disp_src1_val / disp_src2_val  in  XLEN each  operand value when ready.
REQ-014 cdb_valid, cdb_tag [TAG_W], cdb_data [XLEN]  in  result broadcast snoop.
REQ-015 fu_valid  out  1  issue strobe to logical FU.
REQ-016 fu_op [3], fu_rs1 [XLEN], fu_rs2 [XLEN]  out  FU operands.
REQ-017 fu_result  in  XLEN  FU registered result, valid one cycle after fu_valid.
REQ-018 wb_valid, wb_tag [TAG_W], wb_data [XLEN]  out  completion to CDB arbiter.

Function
REQ-019 Each entry SHALL hold valid, op, dst_tag, per-source ready/tag/value, and age rank.
REQ-020 disp_ready SHALL be 1 iff at least one entry is free at the start of the cycle; same-cycle issue SHALL NOT bypass into disp_ready.
REQ-021 Dispatch SHALL occur when disp_valid & disp_ready & !flush; entry written at the clock edge into the lowest-index free slot.
REQ-022 Each cycle with cdb_valid, every valid entry source with ready=0 and tag==cdb_tag SHALL capture cdb_data and set ready=1.
REQ-023 A dispatching source with rdy=0 whose tag matches the same-cycle cdb_tag SHALL be written ready with cdb_data.
REQ-024 An entry SHALL be issue-eligible when valid and both sources ready at the start of the cycle (no same-cycle wakeup-to-issue).
REQ-025 Select SHALL pick the oldest eligible entry by dispatch order; at most one issue per cycle.
REQ-026 fu_valid, fu_op, fu_rs1, fu_rs2 SHALL be combinational from the selected entry; entry freed at that edge.
REQ-027 fu_op/fu_rs1/fu_rs2 SHALL be 0 when fu_valid=0.
REQ-028 Opcodes other than 100/110/111 SHALL be accepted and issued unchanged (FU returns 0).
REQ-029 Write-back SHALL have fixed latency: wb_valid=1 exactly one cycle after fu_valid=1, wb_tag = issued dst_tag (registered), wb_data = fu_result.
REQ-030 wb_data SHALL be 0 and wb_tag 0 when wb_valid=0.
REQ-031 flush SHALL clear all entry valids and the in-flight flag at the edge; wb_valid SHALL be 0 the next cycle; dispatch and issue in the flush cycle are suppressed (fu_valid=0).
REQ-032 Age ranks SHALL remain a strict total order over valid entries under simultaneous dispatch and issue.
REQ-033 Simultaneous dispatch, CDB wakeup, and issue in one cycle SHALL all take effect.

Reset
REQ-034 rst low SHALL immediately clear all entries and in-flight flag regardless of clk.
REQ-035 During and after reset: disp_ready=1, fu_valid=0, fu_op/fu_rs1/fu_rs2=0, wb_valid=0, wb_tag=0, wb_data=0.
REQ-036 Reset asserted mid-operation SHALL drop any in-flight op with no wb_valid after release.

Verification
REQ-037 Ready dispatch: op=100, rs1=0xF0F0F0F0, rs2=0x0FF00FF0, dst=5 at cycle 0 -> fu_valid cycle 1, wb_valid cycle 2, wb_tag=5, wb_data=0xFF00FF00.
REQ-038 Wakeup: dispatch op=111 src1 tag 9 not ready, src2=0xFFFF0000; cdb tag 9 data 0x12345678 cycle 3 -> issue cycle 4, wb_data=0x12340000.
REQ-039 Full: 4 dispatches with unready sources -> disp_ready=0 cycle 4; 5th disp_valid held, not written until an issue frees a slot.
REQ-040 Age: entries A (older) and B both woken by same CDB -> A issues first cycle, B next, wb order A then B.
REQ-041 Flush: issue at cycle N with flush at N -> fu_valid=0 at N, wb_valid=0 at N+1, disp_ready=1 at N+1.
REQ-042 Async reset: rst low between clock edges while an op is in flight -> outputs zero immediately, no wb_valid after release.
